timing_phase_sequencer: RTL and testbench

//  Run/halt/single-step controller for the computer timing chain. Steps the bit-time

---
 rtl/timing_phase_sequencer.sv | 78 +++++++
 tb/tb_timing_phase_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/timing_phase_sequencer.sv
// timing_phase_sequencer: run/halt/step controller stepping the gate/half-bit ring and phase counter
module timing_phase_sequencer #(
   parameter int NGATE  = 7,
   parameter int NPHASE = 4,
   localparam int BW = $clog2(2*NGATE),
   localparam int PW = (NPHASE > 1) ? $clog2(NPHASE) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             run_req,
   input  logic             halt_req,
   input  logic             step_req,
   input  logic             phase_hold,
   output logic [NGATE-1:0] g,
   output logic             a,
   output logic [BW-1:0]    bit_time,
   output logic [PW-1:0]    phase,
   output logic             phase_start,
   output logic             cycle_start,
   output logic             running,
   output logic             halted
);
   typedef enum logic [1:0] {HALTED, RUN, DRAIN, STEP} state_t;
   state_t           state_q, state_d;
   logic [NGATE-1:0] g_q, g_d;
   logic             a_q, a_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [PW-1:0]    phase_q, phase_d;
   logic             ps_q, ps_d, cs_q, cs_d;
   logic             lb, adv, wrap;
   assign lb   = bit_q == BW'(2*NGATE-1);
   assign adv  = state_q != HALTED && tick && !(phase_hold && lb);
   assign wrap = adv && lb;
   // ring/phase advance and next-state selection; a phase boundary is the only exit to HALTED
   always_comb begin
      a_d     = adv ? ~a_q : a_q;
      g_d     = (adv && a_q) ? {g_q[NGATE-2:0], g_q[NGATE-1]} : g_q;
      bit_d   = adv ? (lb ? '0 : bit_q + 1'b1) : bit_q;
      phase_d = wrap ? ((phase_q == PW'(NPHASE-1)) ? '0 : phase_q + 1'b1) : phase_q;
      ps_d    = wrap;
      cs_d    = wrap && phase_d == '0;
      state_d = state_q;
      case (state_q)
         HALTED:  state_d = halt_req ? HALTED : step_req ? STEP : run_req ? RUN : HALTED;
         RUN:     state_d = halt_req ? (wrap ? HALTED : DRAIN) : RUN;
         default: state_d = wrap ? HALTED : state_q;
      endcase
   end
   // state and counter registers; reset drops straight to G1/bit 0 without draining
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HALTED;
         g_q     <= NGATE'(1);
         a_q     <= 1'b0;
         bit_q   <= '0;
         phase_q <= '0;
         ps_q    <= 1'b0;
         cs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         a_q     <= a_d;
         bit_q   <= bit_d;
         phase_q <= phase_d;
         ps_q    <= ps_d;
         cs_q    <= cs_d;
      end
   end
   assign g           = g_q;
   assign a           = a_q;
   assign bit_time    = bit_q;
   assign phase       = phase_q;
   assign phase_start = ps_q;
   assign cycle_start = cs_q;
   assign running     = state_q != HALTED;
   assign halted      = state_q == HALTED;
endmodule

// File: tb/tb_timing_phase_sequencer.sv
// tb_timing_phase_sequencer: scoreboard bench for the timing phase sequencer
module tb_timing_phase_sequencer;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       tick = 1'b0, run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0, phase_hold = 1'b0;
   logic [6:0] g;
   logic       a, phase_start, cycle_start, running, halted;
   logic [3:0] bit_time;
   logic [1:0] phase;
   typedef struct {logic [3:0] b; logic [1:0] p; logic ps; logic cs; logic hl;} exp_t;
   exp_t q[$];
   int tests = 0, fails = 0;
   int m_bit = 0, m_ph = 0, m_st = 0;
   timing_phase_sequencer dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .run_req(run_req), .halt_req(halt_req),
      .step_req(step_req), .phase_hold(phase_hold), .g(g), .a(a), .bit_time(bit_time),
      .phase(phase), .phase_start(phase_start), .cycle_start(cycle_start),
      .running(running), .halted(halted)
   );
   always #5 clk = ~clk;
   // scoreboard: pop the expected state after each edge and compare all outputs
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         exp_t e;
         logic [6:0] eg;
         e = q.pop_front();
         eg = 7'(1) << (e.b / 2);
         tests++;
         if ({g, a, bit_time, phase, phase_start, cycle_start, running, halted} !==
             {eg, e.b[0], e.b, e.p, e.ps, e.cs, ~e.hl, e.hl}) begin
            fails++;
            $display("FAIL scoreboard t=%0t: got g=%b a=%b bit=%0d ph=%0d ps=%b cs=%b run=%b hlt=%b, expected g=%b a=%b bit=%0d ph=%0d ps=%b cs=%b run=%b hlt=%b",
                     $time, g, a, bit_time, phase, phase_start, cycle_start, running, halted,
                     eg, e.b[0], e.b, e.p, e.ps, e.cs, ~e.hl, e.hl);
         end
      end
   end
   // drive one clock of stimulus and push the model's prediction for the following edge
   task automatic cyc(input logic t, input logic r, input logic h, input logic s, input logic hd);
      exp_t e;
      bit act, lb, adv, wrap;
      int ns;
      tick = t; run_req = r; halt_req = h; step_req = s; phase_hold = hd;
      act  = m_st != 0;
      lb   = m_bit == 13;
      adv  = act && t && !(hd && lb);
      wrap = adv && lb;
      case (m_st)
         0:       ns = h ? 0 : s ? 3 : r ? 1 : 0;
         1:       ns = h ? (wrap ? 0 : 2) : 1;
         default: ns = wrap ? 0 : m_st;
      endcase
      if (adv) m_bit = (m_bit + 1) % 14;
      if (wrap) m_ph = (m_ph + 1) % 4;
      m_st = ns;
      e.b = 4'(m_bit); e.p = 2'(m_ph); e.ps = wrap; e.cs = wrap && m_ph == 0; e.hl = (ns == 0);
      q.push_back(e);
      @(posedge clk);
      #2;
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      m_bit = 0; m_ph = 0; m_st = 0;
      #1;
      tests++;
      if ({g, a, bit_time, phase, phase_start, cycle_start, running, halted} !== {7'b1, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL reset_values: got g=%b a=%b bit=%0d ph=%0d ps=%b cs=%b run=%b hlt=%b, expected g=0000001 a=0 bit=0 ph=0 ps=0 cs=0 run=0 hlt=1",
                  g, a, bit_time, phase, phase_start, cycle_start, running, halted);
      end
      #1 rst_n = 1'b1;
   endtask
   task automatic test_reset();
      @(posedge clk);
      #2;
      do_reset();
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
   endtask
   task automatic test_walk();
      int ps_cnt = 0;
      cyc(0, 1, 0, 0, 0);
      for (int i = 0; i < 14; i++) begin
         cyc(1, 0, 0, 0, 0);
         ps_cnt += phase_start;
         if (i % 3 == 1) cyc(0, 0, 0, 0, 0);
      end
      tests++;
      if (ps_cnt !== 1 || phase !== 2'd1 || bit_time !== 4'd0) begin
         fails++;
         $display("FAIL walk: got phase_starts=%0d phase=%0d bit=%0d, expected 1 1 0", ps_cnt, phase, bit_time);
      end
   endtask
   task automatic test_free_run();
      int cs_cnt = 0, cs_at = -1;
      do_reset();
      cyc(0, 1, 0, 0, 0);
      for (int i = 1; i <= 56; i++) begin
         cyc(1, 1, 0, 0, 0);
         if (cycle_start) begin cs_cnt++; cs_at = i; end
      end
      tests++;
      if (cs_cnt !== 1 || cs_at !== 56 || phase !== 2'd0) begin
         fails++;
         $display("FAIL free_run: got cycle_starts=%0d at=%0d phase=%0d, expected 1 56 0", cs_cnt, cs_at, phase);
      end
   endtask
   task automatic test_drain();
      for (int i = 0; i < 33; i++) cyc(1, 1, 0, 0, 0);
      tests++;
      if (bit_time !== 4'd5 || phase !== 2'd2) begin
         fails++;
         $display("FAIL drain_setup: got bit=%0d phase=%0d, expected 5 2", bit_time, phase);
      end
      cyc(0, 1, 1, 0, 0);
      for (int i = 0; i < 9; i++) cyc(1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
      tests++;
      if (halted !== 1'b1 || bit_time !== 4'd0 || phase !== 2'd3) begin
         fails++;
         $display("FAIL drain_halt: got halted=%b bit=%0d phase=%0d, expected 1 0 3", halted, bit_time, phase);
      end
   endtask
   task automatic test_step();
      int adv_cnt = 0;
      logic [3:0] pb;
      cyc(0, 0, 0, 1, 0);
      for (int i = 0; i < 20; i++) begin
         pb = bit_time;
         cyc(1, 1, 1, 0, 0);
         if (bit_time !== pb) adv_cnt++;
      end
      tests++;
      if (adv_cnt !== 14 || halted !== 1'b1 || phase !== 2'd0 || bit_time !== 4'd0) begin
         fails++;
         $display("FAIL step: got advances=%0d halted=%b phase=%0d bit=%0d, expected 14 1 0 0", adv_cnt, halted, phase, bit_time);
      end
   endtask
   task automatic test_hold();
      cyc(0, 1, 0, 0, 0);
      for (int i = 0; i < 13; i++) cyc(1, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1);
      tests++;
      if (bit_time !== 4'd13 || phase !== 2'd0) begin
         fails++;
         $display("FAIL hold: got bit=%0d phase=%0d, expected 13 0", bit_time, phase);
      end
      cyc(1, 0, 0, 0, 0);
      tests++;
      if (bit_time !== 4'd0 || phase_start !== 1'b1 || phase !== 2'd1) begin
         fails++;
         $display("FAIL hold_release: got bit=%0d ps=%b phase=%0d, expected 0 1 1", bit_time, phase_start, phase);
      end
   endtask
   task automatic test_async_reset();
      for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0);
      tests++;
      if (bit_time !== 4'd7) begin
         fails++;
         $display("FAIL async_setup: got bit=%0d, expected 7", bit_time);
      end
      do_reset();
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
   endtask
   initial begin
      test_reset();
      test_walk();
      test_free_run();
      test_drain();
      test_step();
      test_hold();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
